// File: rtl/jam_pkg.sv
// Shared types and elaboration-time helpers for the exhaustive assignment search.
package jam_pkg;

  localparam int unsigned MAX_ORD_W = 24;

  typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} jam_state_e;

  function automatic int unsigned f_iw(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned f_sw(input int unsigned n, input int unsigned cw);
    int unsigned m;
    m = (32'd1 << cw) - 32'd1;
    return $clog2(n * m + 32'd1);
  endfunction

  function automatic int unsigned f_fact(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 2; i <= n; i++) r = r * i;
    return r;
  endfunction

  // Identity order packed at iw bits per worker; caller truncates to N*iw.
  function automatic logic [MAX_ORD_W-1:0] f_identity(input int unsigned n, input int unsigned iw);
    logic [MAX_ORD_W-1:0] r;
    r = '0;
    for (int unsigned p = 0; p < n; p++) r = r | (MAX_ORD_W'(p) << (p * iw));
    return r;
  endfunction

endpackage

// File: rtl/jam_next_perm.sv
// Combinational successor of a packed permutation in lexicographic order.
module jam_next_perm #(
  parameter int unsigned N  = 8,
  parameter int unsigned IW = 3
) (
  input  logic [N*IW-1:0] order_i,
  output logic [N*IW-1:0] next_o,
  output logic            is_last_o
);

  logic [IW-1:0] a [N];
  logic [IW-1:0] b [N];
  int            piv;
  int            succ;
  logic          found;

  // Pivot = rightmost ascent; swap with rightmost larger element, then reverse the tail.
  always_comb begin
    found  = 1'b0;
    piv    = 0;
    succ   = 0;
    next_o = '0;
    for (int p = 0; p < N; p++) a[p] = order_i[p*IW +: IW];
    for (int p = 0; p < N - 1; p++) begin
      if (a[p] < a[p+1]) begin
        found = 1'b1;
        piv   = p;
      end
    end
    for (int p = 0; p < N; p++) begin
      if ((p > piv) && (a[p] > a[piv])) succ = p;
    end
    b       = a;
    b[piv]  = a[succ];
    b[succ] = a[piv];
    for (int p = 0; p < N; p++) begin
      if (p > piv) next_o[p*IW +: IW] = b[N + piv - p];
      else         next_o[p*IW +: IW] = b[p];
    end
    is_last_o = ~found;
  end

endmodule

// File: rtl/jam_perm_search.sv
// Brute-force assignment solver: loads an N x N cost matrix, scores every
// permutation and reports the best total, its multiplicity and first best order.
module jam_perm_search
  import jam_pkg::*;
#(
  parameter  int unsigned N   = 8,
  parameter  int unsigned CW  = 7,
  parameter  int unsigned MCW = 16,
  localparam int unsigned IW  = f_iw(N),
  localparam int unsigned SW  = f_sw(N, CW)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            Start,
  input  logic            Mode,
  output logic [IW-1:0]   W,
  output logic [IW-1:0]   J,
  input  logic [CW-1:0]   Cost,
  output logic            Busy,
  output logic            Valid,
  output logic [SW-1:0]   MinCost,
  output logic [MCW-1:0]  MatchCount,
  output logic [N*IW-1:0] BestOrder
);

  localparam int unsigned OW       = N * IW;
  localparam int unsigned CNTW     = $clog2(N * N + 1);
  localparam int unsigned NPERM    = f_fact(N);
  localparam logic [OW-1:0] ID_ORD = OW'(f_identity(N, IW));
  localparam logic [IW-1:0] LAST   = IW'(N - 1);

  if (MCW < $clog2(NPERM + 1)) begin : g_mcw_check
    $error("MCW too narrow for N! matches");
  end

  jam_state_e      state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [IW-1:0]   w_q, w_d, j_q, j_d;
  logic [IW-1:0]   cw_q, cw_d, cj_q, cj_d;
  logic            mode_q, mode_d;
  logic [IW-1:0]   k_q, k_d;
  logic [SW-1:0]   acc_q, acc_d;
  logic [OW-1:0]   ord_q, ord_d;
  logic            first_q, first_d;
  logic [SW-1:0]   rbest_q, rbest_d;
  logic [MCW-1:0]  rcnt_q, rcnt_d;
  logic [OW-1:0]   rord_q, rord_d;
  logic            busy_q, busy_d, valid_q, valid_d;
  logic [SW-1:0]   min_q, min_d;
  logic [MCW-1:0]  mcnt_q, mcnt_d;
  logic [OW-1:0]   bord_q, bord_d;

  logic [CW-1:0]   mat_q [N][N];
  logic            mat_we_c;
  logic [CW-1:0]   ent_c;
  logic [SW-1:0]   sum_c;
  logic            better_c;
  logic [OW-1:0]   next_c;
  logic            last_c;

  jam_next_perm #(.N(N), .IW(IW)) u_next (
    .order_i  (ord_q),
    .next_o   (next_c),
    .is_last_o(last_c)
  );

  // Full-width sum of the permutation in flight, including this cycle's entry.
  assign ent_c    = mat_q[k_q][ord_q[k_q*IW +: IW]];
  assign sum_c    = acc_q + SW'(ent_c);
  assign better_c = mode_q ? (sum_c > rbest_q) : (sum_c < rbest_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    w_d      = w_q;
    j_d      = j_q;
    cw_d     = cw_q;
    cj_d     = cj_q;
    mode_d   = mode_q;
    k_d      = k_q;
    acc_d    = acc_q;
    ord_d    = ord_q;
    first_d  = first_q;
    rbest_d  = rbest_q;
    rcnt_d   = rcnt_q;
    rord_d   = rord_q;
    busy_d   = busy_q;
    valid_d  = valid_q;
    min_d    = min_q;
    mcnt_d   = mcnt_q;
    bord_d   = bord_q;
    mat_we_c = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          state_d = LOAD;
          cnt_d   = '0;
          w_d     = '0;
          j_d     = '0;
          mode_d  = Mode;
          busy_d  = 1'b1;
          valid_d = 1'b0;
        end
      end
      LOAD: begin
        // Cost arrives one cycle after its address, so capture uses the lagged index.
        cw_d     = w_q;
        cj_d     = j_q;
        cnt_d    = cnt_q + CNTW'(1);
        mat_we_c = (cnt_q != '0);
        if (j_q == LAST) begin
          j_d = '0;
          w_d = (w_q == LAST) ? '0 : w_q + IW'(1);
        end else begin
          j_d = j_q + IW'(1);
        end
        if (cnt_q == CNTW'(N * N)) begin
          state_d = CALC;
          w_d     = '0;
          j_d     = '0;
          k_d     = '0;
          acc_d   = '0;
          ord_d   = ID_ORD;
          first_d = 1'b1;
        end
      end
      CALC: begin
        if (k_q == LAST) begin
          acc_d   = '0;
          k_d     = '0;
          ord_d   = next_c;
          first_d = 1'b0;
          if (first_q || better_c) begin
            rbest_d = sum_c;
            rcnt_d  = MCW'(1);
            rord_d  = ord_q;
          end else if ((sum_c == rbest_q) && (rcnt_q != '1)) begin
            rcnt_d = rcnt_q + MCW'(1);
          end
          if (last_c) begin
            state_d = DONE;
            busy_d  = 1'b0;
            valid_d = 1'b1;
            min_d   = rbest_d;
            mcnt_d  = rcnt_d;
            bord_d  = rord_d;
          end
        end else begin
          acc_d = sum_c;
          k_d   = k_q + IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      w_q     <= '0;
      j_q     <= '0;
      cw_q    <= '0;
      cj_q    <= '0;
      mode_q  <= 1'b0;
      k_q     <= '0;
      acc_q   <= '0;
      ord_q   <= ID_ORD;
      first_q <= 1'b0;
      rbest_q <= '0;
      rcnt_q  <= '0;
      rord_q  <= ID_ORD;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      min_q   <= '0;
      mcnt_q  <= '0;
      bord_q  <= ID_ORD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      j_q     <= j_d;
      cw_q    <= cw_d;
      cj_q    <= cj_d;
      mode_q  <= mode_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      ord_q   <= ord_d;
      first_q <= first_d;
      rbest_q <= rbest_d;
      rcnt_q  <= rcnt_d;
      rord_q  <= rord_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      min_q   <= min_d;
      mcnt_q  <= mcnt_d;
      bord_q  <= bord_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          mat_q[r][c] <= '0;
    end else if (mat_we_c) begin
      mat_q[cw_q][cj_q] <= Cost;
    end
  end

  assign W          = w_q;
  assign J          = j_q;
  assign Busy       = busy_q;
  assign Valid      = valid_q;
  assign MinCost    = min_q;
  assign MatchCount = mcnt_q;
  assign BestOrder  = bord_q;

endmodule

// File: tb/tb_jam_perm_search.sv
// Directed checks of jam_perm_search at N = 4, 6, 3 and 2 with hand-computed results.
module tb_jam_perm_search;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // N=4, CW=7
  logic s4, m4, busy4, val4;
  logic [1:0] w4, j4;
  logic [6:0] c4;
  logic [8:0] mc4;
  logic [15:0] cnt4;
  logic [7:0] bo4;
  int tbl4 [4][4];
  always @(posedge CLK) c4 <= 7'(tbl4[w4][j4]);
  jam_perm_search #(.N(4), .CW(7), .MCW(16)) u4 (
    .CLK(CLK), .RST(RST), .Start(s4), .Mode(m4), .W(w4), .J(j4), .Cost(c4),
    .Busy(busy4), .Valid(val4), .MinCost(mc4), .MatchCount(cnt4), .BestOrder(bo4));

  // N=6, CW=7
  logic s6, m6, busy6, val6;
  logic [2:0] w6, j6;
  logic [6:0] c6;
  logic [9:0] mc6;
  logic [15:0] cnt6;
  logic [17:0] bo6;
  int tbl6 [6][6];
  always @(posedge CLK) c6 <= 7'(tbl6[w6][j6]);
  jam_perm_search #(.N(6), .CW(7), .MCW(16)) u6 (
    .CLK(CLK), .RST(RST), .Start(s6), .Mode(m6), .W(w6), .J(j6), .Cost(c6),
    .Busy(busy6), .Valid(val6), .MinCost(mc6), .MatchCount(cnt6), .BestOrder(bo6));

  // N=3, CW=7
  logic s3, m3, busy3, val3;
  logic [1:0] w3, j3;
  logic [6:0] c3;
  logic [8:0] mc3;
  logic [15:0] cnt3;
  logic [5:0] bo3;
  int tbl3 [3][3];
  always @(posedge CLK) c3 <= 7'(tbl3[w3][j3]);
  jam_perm_search #(.N(3), .CW(7), .MCW(16)) u3 (
    .CLK(CLK), .RST(RST), .Start(s3), .Mode(m3), .W(w3), .J(j3), .Cost(c3),
    .Busy(busy3), .Valid(val3), .MinCost(mc3), .MatchCount(cnt3), .BestOrder(bo3));

  // N=2, CW=7
  logic s2, m2, busy2, val2;
  logic w2, j2;
  logic [6:0] c2;
  logic [7:0] mc2;
  logic [15:0] cnt2;
  logic [1:0] bo2;
  int tbl2 [2][2];
  always @(posedge CLK) c2 <= 7'(tbl2[w2][j2]);
  jam_perm_search #(.N(2), .CW(7), .MCW(16)) u2 (
    .CLK(CLK), .RST(RST), .Start(s2), .Mode(m2), .W(w2), .J(j2), .Cost(c2),
    .Busy(busy2), .Valid(val2), .MinCost(mc2), .MatchCount(cnt2), .BestOrder(bo2));

  // Each run pulses Start for one cycle and returns cycles until Valid (-1 on timeout).
  task automatic run4(input logic mode, input int inj, output int lat);
    m4 = mode; s4 = 1'b1; lat = -1;
    for (int n = 1; n <= 300; n++) begin
      @(posedge CLK); #1;
      s4 = (n == inj);
      if (val4) begin lat = n; break; end
    end
    s4 = 1'b0;
  endtask

  task automatic run6(input logic mode, output int lat);
    m6 = mode; s6 = 1'b1; lat = -1;
    for (int n = 1; n <= 5000; n++) begin
      @(posedge CLK); #1;
      s6 = 1'b0;
      if (val6) begin lat = n; break; end
    end
  endtask

  task automatic run3(input logic mode, output int lat);
    m3 = mode; s3 = 1'b1; lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge CLK); #1;
      s3 = 1'b0;
      if (val3) begin lat = n; break; end
    end
  endtask

  task automatic run2(input logic mode, output int lat);
    m2 = mode; s2 = 1'b1; lat = -1;
    for (int n = 1; n <= 50; n++) begin
      @(posedge CLK); #1;
      s2 = 1'b0;
      if (val2) begin lat = n; break; end
    end
  endtask

  int lat;

  initial begin
    RST = 1'b1;
    s4 = 0; m4 = 0; s6 = 0; m6 = 0; s3 = 0; m3 = 0; s2 = 0; m2 = 0;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) tbl4[i][j] = (i == j) ? 10 : 20;
    for (int i = 0; i < 6; i++) for (int j = 0; j < 6; j++) tbl6[i][j] = 127;
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) tbl3[i][j] = (i + 2 * j) % 3 + 1;
    tbl2[0][0] = 1; tbl2[0][1] = 9; tbl2[1][0] = 9; tbl2[1][1] = 1;

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy", busy4, 0);
    chk("rst_valid", val4, 0);
    chk("rst_mincost", mc4, 0);
    chk("rst_count", cnt4, 0);
    chk("rst_order", bo4, 8'hE4);
    chk("rst_wj", {w4, j4}, 0);
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("post_rst_valid", val4, 0);
    chk("post_rst_order", bo4, 8'hE4);

    // Diagonal 10, off-diagonal 20
    run4(1'b0, -1, lat);
    chk("diag_min_lat", lat, 114);
    chk("diag_min_cost", mc4, 40);
    chk("diag_min_count", cnt4, 1);
    chk("diag_min_order", bo4, 8'hE4);
    chk("diag_min_busy", busy4, 0);
    repeat (3) @(posedge CLK);
    #1;
    chk("done_hold_valid", val4, 1);
    chk("done_hold_cost", mc4, 40);

    // Maximise: best are the 9 derangements, first is (1,0,3,2)
    run4(1'b1, -1, lat);
    chk("diag_max_lat", lat, 114);
    chk("diag_max_cost", mc4, 80);
    chk("diag_max_count", cnt4, 9);
    chk("diag_max_order", bo4, 8'hB1);

    // Start pulsed mid-CALC must be ignored
    run4(1'b0, 50, lat);
    chk("ign_start_lat", lat, 114);
    chk("ign_start_cost", mc4, 40);
    chk("ign_start_count", cnt4, 1);

    // All equal costs, both objectives
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) tbl4[i][j] = 5;
    run4(1'b0, -1, lat);
    chk("flat_min_cost", mc4, 20);
    chk("flat_min_count", cnt4, 24);
    chk("flat_min_order", bo4, 8'hE4);
    run4(1'b1, -1, lat);
    chk("flat_max_lat", lat, 114);
    chk("flat_max_cost", mc4, 20);
    chk("flat_max_count", cnt4, 24);
    chk("flat_max_order", bo4, 8'hE4);

    // Reset in the middle of CALC, then a clean rerun
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) tbl4[i][j] = (i == j) ? 10 : 20;
    m4 = 1'b0; s4 = 1'b1;
    @(posedge CLK); #1; s4 = 1'b0;
    repeat (40) @(posedge CLK);
    #1;
    chk("pre_abort_busy", busy4, 1);
    RST = 1'b1;
    #2;
    chk("abort_valid", val4, 0);
    chk("abort_busy", busy4, 0);
    chk("abort_cost", mc4, 0);
    chk("abort_count", cnt4, 0);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    run4(1'b0, -1, lat);
    chk("rerun_lat", lat, 114);
    chk("rerun_cost", mc4, 40);
    chk("rerun_count", cnt4, 1);
    chk("rerun_order", bo4, 8'hE4);

    // N=6 full-scale costs, maximise: no accumulator overflow
    run6(1'b1, lat);
    chk("n6_lat", lat, 4358);
    chk("n6_cost", mc6, 762);
    chk("n6_count", cnt6, 720);
    chk("n6_order", bo6, 18'o543210);

    // N=3 (i+2j) mod 3 + 1: sums 3,6,6,9,6,6 over lexicographic perms
    run3(1'b0, lat);
    chk("n3_lat", lat, 29);
    chk("n3_min_cost", mc3, 3);
    chk("n3_min_count", cnt3, 1);
    chk("n3_min_order", bo3, 6'b10_01_00);
    run3(1'b1, lat);
    chk("n3_max_cost", mc3, 9);
    chk("n3_max_count", cnt3, 1);
    chk("n3_max_order", bo3, 6'b00_10_01);

    // N=2 {{1,9},{9,1}}
    run2(1'b1, lat);
    chk("n2_lat", lat, 10);
    chk("n2_max_cost", mc2, 18);
    chk("n2_max_count", cnt2, 1);
    chk("n2_max_order", bo2, 2'b01);
    run2(1'b0, lat);
    chk("n2_min_cost", mc2, 2);
    chk("n2_min_count", cnt2, 1);
    chk("n2_min_order", bo2, 2'b10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jam_perm_search.md
JAM_PERM_SEARCH -- requirements
Module: jam_perm_search

Interface
REQ-001 SHALL have parameter N, default 8, meaning number of workers and number of jobs; legal range 2..8.
REQ-002 SHALL have parameter CW, default 7, meaning the width of one cost entry.
REQ-003 SHALL have parameter MCW, default 16, meaning the MatchCount width; it SHALL be at least ceil(log2(N!+1)).
REQ-004 SHALL define derived widths IW = max(1, ceil(log2 N)) and SW = ceil(log2(N*(2^CW-1)+1)).
REQ-005 CLK  input  1  clock; reset RST, asynchronous, active-high.
REQ-006 RST  input  1  asynchronous active-high reset.
REQ-007 Start  input  1  one-cycle pulse that begins a new search.
REQ-008 Mode  input  1  objective: 0 = minimise total cost, 1 = maximise; sampled at accepted Start.
REQ-009 W  output  IW  worker index of the cost request.
REQ-010 J  output  IW  job index of the cost request.
REQ-011 Cost  input  CW  cost[W][J], valid the cycle after W/J are presented.
REQ-012 Busy  output  1  high from accepted Start until Valid rises.
REQ-013 Valid  output  1  results final; held until next accepted Start.
REQ-014 MinCost  output  SW  best (min or max per Mode) total cost.
REQ-015 MatchCount  output  MCW  number of permutations achieving the best total cost.
REQ-016 BestOrder  output  N*IW  job assigned to each worker, worker w at bits [w*IW +: IW], for the lexicographically first best permutation.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, CALC, DONE; the reset state SHALL be IDLE.
REQ-018 Start SHALL be accepted only in IDLE or DONE; on acceptance the FSM SHALL enter LOAD, clear Valid, set Busy and latch Mode.
REQ-019 Start in LOAD or CALC SHALL be ignored.
REQ-020 LOAD SHALL present W/J row-major: (0,0), (0,1), ... (N-1,N-1), one pair per cycle.
REQ-021 LOAD SHALL capture Cost one cycle later into an internal N x N matrix; LOAD SHALL last N*N+1 cycles.
REQ-022 CALC SHALL enumerate all N! permutations in lexicographic order, starting from identity (0,1,...,N-1).
REQ-023 CALC SHALL accumulate one matrix entry cost[k][order[k]] per cycle, taking N cycles per permutation.
REQ-024 The next permutation SHALL be computed combinationally during the final accumulation cycle and loaded with zero added bubble cycles.
REQ-025 Completion of the first permutation SHALL initialise MinCost to its sum, MatchCount to 1 and BestOrder to identity.
REQ-026 For each later permutation, a strictly better sum (< if Mode=0, > if Mode=1) SHALL replace MinCost and BestOrder and set MatchCount to 1.
REQ-027 For each later permutation, an equal sum SHALL increment MatchCount, saturating at all-ones, and leave BestOrder unchanged.
REQ-028 The comparison SHALL use the full-width sum of the permutation currently completing, never the previous partial sum.
REQ-029 The accumulator SHALL be SW bits wide and SHALL never overflow.
REQ-030 After the last permutation (N-1,...,0) is scored, the FSM SHALL enter DONE, drop Busy and raise Valid.
REQ-031 Total Start-to-Valid latency SHALL be exactly N*N+1+N*N!+1 cycles.
REQ-032 In DONE, results SHALL remain stable; Start SHALL restart with fresh costs.

Reset
REQ-033 RST SHALL set the FSM to IDLE, W and J to 0, Busy and Valid to 0, MinCost to 0, MatchCount to 0, BestOrder to identity, and clear the matrix.
REQ-034 RST asserted mid-LOAD or mid-CALC SHALL abort the search immediately with no partial result visible.
REQ-035 After RST deassertion, outputs SHALL be stable until the next Start.

Structure
REQ-036 Package jam_pkg SHALL hold the state enum, the width-computation functions (IW, SW, factorial) and the identity-order constant function.
REQ-037 Sub-module jam_next_perm SHALL be purely combinational, taking an order vector and producing the next lexicographic order plus an is_last flag.
REQ-038 Cost storage, accumulation and compare SHALL stay in jam_perm_search.

Verification
REQ-039 N=4, Mode=0, cost[i][j]=10 for i==j else 20 -> MinCost=40, MatchCount=1, BestOrder=(0,1,2,3), Valid exactly 16+1+96+1 cycles after Start.
REQ-040 N=4, all costs=5 -> MinCost=20, MatchCount=24, BestOrder=identity; repeat with Mode=1 -> same results.
REQ-041 N=8, CW=7, all costs=127, Mode=1 -> MinCost=1016 with no overflow, MatchCount=40320.
REQ-042 N=3, cost[i][j]=(i+2j) mod 3 +1, Mode=0 -> result matches software brute-force minimum, MatchCount and first lexicographic order.
REQ-043 Start pulsed mid-CALC -> ignored, result unchanged; RST mid-CALC -> Valid=0, Busy=0, MinCost=0, then new Start completes correctly.
REQ-044 N=2, cost = {{1,9},{9,1}}, Mode=1 -> MinCost=18, MatchCount=1, BestOrder=(1,0).
